// File: rtl/clint_irq_ctrl.sv
// Core-local interrupt/trap controller beside the ID stage.
// Arbitrates level-sensitive interrupts against ECALL/EBREAK/MRET in ID.
// Sequences the mepc/mstatus/mcause CSR writes one per cycle while stalling IF/ID.
// Finishes with a single-cycle redirect to the trap handler or to mepc.
module clint_irq_ctrl #(
   parameter int NUM_IRQ  = 4,
   parameter int XLEN     = 32,
   parameter int IRQ_BASE = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XLEN-1:0]    inst,
   input  logic               inst_valid,
   input  logic [XLEN-1:0]    pc,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_en,
   input  logic [XLEN-1:0]    csr_mstatus,
   input  logic [XLEN-1:0]    csr_mepc,
   input  logic [XLEN-1:0]    csr_mtvec,
   output logic               csr_we,
   output logic [11:0]        csr_wa,
   output logic [XLEN-1:0]    csr_wd,
   output logic               stall,
   output logic               jump_flag,
   output logic [XLEN-1:0]    jump_addr,
   output logic [XLEN-1:0]    trap_cause
);

   localparam logic [XLEN-1:0] ECALL_I  = XLEN'(32'h0000_0073);
   localparam logic [XLEN-1:0] EBREAK_I = XLEN'(32'h0010_0073);
   localparam logic [XLEN-1:0] MRET_I   = XLEN'(32'h3020_0073);
   localparam logic [XLEN-1:0] INT_BIT  = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MEPC,
      S_MSTATUS,
      S_MCAUSE,
      S_MRET_MST,
      S_JUMP
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   mstatus_q, mstatus_d;
   logic [XLEN-1:0]   cause_q, cause_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic [XLEN-1:0]   trap_cause_q, trap_cause_d;

   logic              irq_hit;
   logic [XLEN-1:0]   irq_code;
   logic              is_ecall, is_ebreak, is_mret;
   logic              take_exc, take_irq, take_mret;
   logic [XLEN-1:0]   tvec_base;

   // Trap entry: MPIE takes the old MIE, MIE is cleared.
   function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
      logic [XLEN-1:0] r;
      r    = ms;
      r[7] = ms[3];
      r[3] = 1'b0;
      return r;
   endfunction

   // MRET: MIE restored from MPIE, MPIE set.
   function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
      logic [XLEN-1:0] r;
      r    = ms;
      r[3] = ms[7];
      r[7] = 1'b1;
      return r;
   endfunction

   // Find the lowest-index enabled request; scanning downward lets the lowest win.
   always_comb begin
      irq_hit  = 1'b0;
      irq_code = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq[i] && irq_en[i]) begin
            irq_hit  = 1'b1;
            irq_code = XLEN'(IRQ_BASE) + XLEN'(i);
         end
      end
   end

   assign is_ecall  = (inst == ECALL_I);
   assign is_ebreak = (inst == EBREAK_I);
   assign is_mret   = (inst == MRET_I);
   assign tvec_base = {csr_mtvec[XLEN-1:2], 2'b00};

   // Events are only considered in IDLE with a real instruction in ID.
   always_comb begin
      take_exc  = 1'b0;
      take_irq  = 1'b0;
      take_mret = 1'b0;
      if (state_q == S_IDLE && inst_valid) begin
         take_exc  = is_ecall || is_ebreak;
         take_irq  = !take_exc && irq_hit && csr_mstatus[3];
         take_mret = !take_exc && !take_irq && is_mret;
      end
   end

   // Next-state and latching of trap context at detection.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      mstatus_d    = mstatus_q;
      cause_d      = cause_q;
      target_d     = target_q;
      trap_cause_d = trap_cause_q;
      case (state_q)
         S_IDLE: begin
            if (take_exc || take_irq) begin
               state_d   = S_MEPC;
               pc_d      = pc;
               mstatus_d = csr_mstatus;
               if (take_exc) begin
                  cause_d  = is_ecall ? XLEN'(11) : XLEN'(3);
                  target_d = tvec_base;
               end else begin
                  cause_d  = irq_code | INT_BIT;
                  // Only mode 1 vectors; reserved modes fall back to direct.
                  target_d = (csr_mtvec[1:0] == 2'b01) ? tvec_base + (irq_code << 2)
                                                       : tvec_base;
               end
            end else if (take_mret) begin
               state_d   = S_MRET_MST;
               pc_d      = pc;
               mstatus_d = csr_mstatus;
               target_d  = csr_mepc;
            end
         end
         S_MEPC:     state_d = S_MSTATUS;
         S_MSTATUS: begin
            state_d      = S_MCAUSE;
            trap_cause_d = cause_q;
         end
         S_MCAUSE:   state_d = S_JUMP;
         S_MRET_MST: state_d = S_JUMP;
         S_JUMP:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // CSR port, redirect and stall; everything is zero outside its owning state.
   always_comb begin
      csr_we    = 1'b0;
      csr_wa    = '0;
      csr_wd    = '0;
      jump_flag = 1'b0;
      jump_addr = '0;
      stall     = (state_q != S_IDLE) ||
                  ((take_exc || take_irq || take_mret) && !rst);
      case (state_q)
         S_MEPC: begin
            csr_we = 1'b1;
            csr_wa = CSR_MEPC;
            csr_wd = pc_q;
         end
         S_MSTATUS: begin
            csr_we = 1'b1;
            csr_wa = CSR_MSTATUS;
            csr_wd = mstatus_on_trap(mstatus_q);
         end
         S_MCAUSE: begin
            csr_we = 1'b1;
            csr_wa = CSR_MCAUSE;
            csr_wd = cause_q;
         end
         S_MRET_MST: begin
            csr_we = 1'b1;
            csr_wa = CSR_MSTATUS;
            csr_wd = mstatus_on_mret(mstatus_q);
         end
         S_JUMP: begin
            jump_flag = 1'b1;
            jump_addr = target_q;
         end
         default: ;
      endcase
   end

   assign trap_cause = trap_cause_q;

   // State and trap-context registers; reset aborts any sequence in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         mstatus_q    <= '0;
         cause_q      <= '0;
         target_q     <= '0;
         trap_cause_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         mstatus_q    <= mstatus_d;
         cause_q      <= cause_d;
         target_q     <= target_d;
         trap_cause_q <= trap_cause_d;
      end
   end

endmodule

// File: tb/tb_clint_irq_ctrl.sv
// Directed bench for clint_irq_ctrl: expected CSR writes and redirects are queued
// when a trap/MRET is provoked and popped as the DUT emits them.
module tb_clint_irq_ctrl;

   localparam int NUM_IRQ = 4;
   localparam int XLEN    = 32;

   localparam logic [31:0] ECALL_I  = 32'h0000_0073;
   localparam logic [31:0] EBREAK_I = 32'h0010_0073;
   localparam logic [31:0] MRET_I   = 32'h3020_0073;
   localparam logic [31:0] NOP_I    = 32'h0000_0013;

   logic               clk = 1'b0;
   logic               rst;
   logic [XLEN-1:0]    inst;
   logic               inst_valid;
   logic [XLEN-1:0]    pc;
   logic [NUM_IRQ-1:0] irq;
   logic [NUM_IRQ-1:0] irq_en;
   logic [XLEN-1:0]    csr_mstatus;
   logic [XLEN-1:0]    csr_mepc;
   logic [XLEN-1:0]    csr_mtvec;
   logic               csr_we;
   logic [11:0]        csr_wa;
   logic [XLEN-1:0]    csr_wd;
   logic               stall;
   logic               jump_flag;
   logic [XLEN-1:0]    jump_addr;
   logic [XLEN-1:0]    trap_cause;

   typedef struct {
      logic [11:0] wa;
      logic [31:0] wd;
   } wr_t;

   wr_t         wq[$];
   logic [31:0] jq[$];
   int          checks = 0;
   int          errors = 0;

   clint_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .XLEN(XLEN), .IRQ_BASE(16)) dut (
      .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .pc(pc),
      .irq(irq), .irq_en(irq_en), .csr_mstatus(csr_mstatus), .csr_mepc(csr_mepc),
      .csr_mtvec(csr_mtvec), .csr_we(csr_we), .csr_wa(csr_wa), .csr_wd(csr_wd),
      .stall(stall), .jump_flag(jump_flag), .jump_addr(jump_addr),
      .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then pop/compare anything the DUT emitted this cycle.
   task automatic tick();
      wr_t         e;
      logic [31:0] j;
      @(posedge clk);
      #1;
      if (csr_we) begin
         if (wq.size() == 0) chk("spurious_csr_we", csr_we, 0);
         else begin
            e = wq.pop_front();
            chk("csr_wa", csr_wa, e.wa);
            chk("csr_wd", csr_wd, e.wd);
         end
      end else begin
         chk("csr_wa_idle", csr_wa, 0);
         chk("csr_wd_idle", csr_wd, 0);
      end
      if (jump_flag) begin
         if (jq.size() == 0) chk("spurious_jump", jump_flag, 0);
         else begin
            j = jq.pop_front();
            chk("jump_addr", jump_addr, j);
         end
      end else begin
         chk("jump_addr_idle", jump_addr, 0);
      end
   endtask

   task automatic push_trap(input logic [31:0] epc, input logic [31:0] ms_exp,
                            input logic [31:0] cause, input logic [31:0] tgt);
      wq.push_back('{wa: 12'h341, wd: epc});
      wq.push_back('{wa: 12'h300, wd: ms_exp});
      wq.push_back('{wa: 12'h342, wd: cause});
      jq.push_back(tgt);
   endtask

   // Called during cycle T of a trap: checks stall over T..T+5 and drains the queues.
   task automatic run_trap_seq(input logic [31:0] cause);
      chk("stall_T", stall, 1);
      tick();
      inst_valid = 1'b0;
      irq        = '0;
      repeat (4) begin
         chk("stall_seq", stall, 1);
         tick();
      end
      chk("stall_done", stall, 0);
      chk("wq_drained", wq.size(), 0);
      chk("jq_drained", jq.size(), 0);
      chk("trap_cause", trap_cause, cause);
   endtask

   initial begin
      rst         = 1'b1;
      inst        = NOP_I;
      inst_valid  = 1'b0;
      pc          = '0;
      irq         = '0;
      irq_en      = '0;
      csr_mstatus = '0;
      csr_mepc    = '0;
      csr_mtvec   = '0;
      tick();
      tick();
      chk("rst_stall", stall, 0);
      chk("rst_we", csr_we, 0);
      chk("rst_jump", jump_flag, 0);
      chk("rst_trap_cause", trap_cause, 0);
      rst = 1'b0;
      tick();

      // ECALL, direct mtvec
      csr_mstatus = 32'h8;
      csr_mtvec   = 32'h800;
      pc          = 32'h100;
      inst        = ECALL_I;
      inst_valid  = 1'b1;
      push_trap(32'h100, 32'h80, 32'd11, 32'h800);
      #1;
      run_trap_seq(32'd11);

      // Reset in the middle of an ECALL sequence
      pc         = 32'h140;
      inst       = ECALL_I;
      inst_valid = 1'b1;
      wq.push_back('{wa: 12'h341, wd: 32'h140});
      wq.push_back('{wa: 12'h300, wd: 32'h80});
      #1;
      chk("rst_mid_stall_T", stall, 1);
      tick();
      inst_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_we", csr_we, 0);
      chk("rst_mid_stall", stall, 0);
      chk("rst_mid_jump", jump_flag, 0);
      chk("rst_mid_trap_cause", trap_cause, 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("rst_mid_stall_after", stall, 0);
      chk("rst_mid_wq", wq.size(), 0);

      // Vectored interrupt, irq[1] beats irq[2]
      csr_mstatus = 32'h8;
      csr_mtvec   = 32'h1001;
      irq_en      = 4'b1111;
      irq         = 4'b0110;
      pc          = 32'h200;
      inst        = NOP_I;
      inst_valid  = 1'b1;
      push_trap(32'h200, 32'h80, 32'h8000_0011, 32'h1044);
      #1;
      run_trap_seq(32'h8000_0011);

      // Masking by irq_en and by MIE
      csr_mtvec   = 32'h800;
      pc          = 32'h300;
      inst        = NOP_I;
      inst_valid  = 1'b1;
      irq         = 4'b0001;
      irq_en      = 4'b0000;
      csr_mstatus = 32'h8;
      #1;
      chk("mask_en_stall", stall, 0);
      tick();
      tick();
      irq_en      = 4'b0001;
      csr_mstatus = 32'h0;
      #1;
      chk("mask_mie_stall", stall, 0);
      tick();
      tick();
      csr_mstatus = 32'h8;
      push_trap(32'h300, 32'h80, 32'h8000_0010, 32'h800);
      #1;
      // run_trap_seq drops irq; raise it again to mimic a still-pending line
      chk("unmask_stall_T", stall, 1);
      tick();
      csr_mstatus = 32'h80;
      repeat (4) begin
         chk("unmask_stall_seq", stall, 1);
         tick();
      end
      chk("unmask_stall_done", stall, 0);
      chk("unmask_trap_cause", trap_cause, 32'h8000_0010);
      // MIE now clear in software's mstatus: the held irq is not re-taken
      tick();
      chk("no_retake_stall", stall, 0);
      tick();
      chk("no_retake_wq", wq.size(), 0);
      inst_valid = 1'b0;
      irq        = '0;

      // MRET followed by an interrupt that becomes pending mid-sequence
      csr_mstatus = 32'h80;
      csr_mepc    = 32'h204;
      csr_mtvec   = 32'h800;
      pc          = 32'h50;
      inst        = MRET_I;
      inst_valid  = 1'b1;
      wq.push_back('{wa: 12'h300, wd: 32'h88});
      jq.push_back(32'h204);
      #1;
      chk("mret_stall_T", stall, 1);
      tick();
      csr_mepc    = 32'h999;
      irq         = 4'b0001;
      irq_en      = 4'b0001;
      csr_mstatus = 32'h88;
      inst        = NOP_I;
      pc          = 32'h60;
      #1;
      chk("mret_stall_T1", stall, 1);
      tick();
      chk("mret_stall_T2", stall, 1);
      tick();
      chk("mret_wq", wq.size(), 0);
      push_trap(32'h60, 32'h80, 32'h8000_0010, 32'h800);
      run_trap_seq(32'h8000_0010);

      // ECALL outranks a pending interrupt; nothing happens without inst_valid
      csr_mstatus = 32'h8;
      csr_mtvec   = 32'h800;
      irq         = 4'b0001;
      irq_en      = 4'b0001;
      inst        = ECALL_I;
      pc          = 32'h400;
      inst_valid  = 1'b0;
      #1;
      chk("invalid_stall", stall, 0);
      tick();
      tick();
      inst_valid = 1'b1;
      push_trap(32'h400, 32'h80, 32'd11, 32'h800);
      #1;
      run_trap_seq(32'd11);

      // EBREAK with vectored mtvec still goes to base
      csr_mstatus = 32'h0;
      csr_mtvec   = 32'h1001;
      inst        = EBREAK_I;
      pc          = 32'h500;
      inst_valid  = 1'b1;
      push_trap(32'h500, 32'h0, 32'd3, 32'h1000);
      #1;
      run_trap_seq(32'd3);

      // Reserved mtvec mode behaves as direct for interrupts
      csr_mstatus = 32'h88;
      csr_mtvec   = 32'h1002;
      irq         = 4'b0100;
      irq_en      = 4'b1111;
      inst        = NOP_I;
      pc          = 32'h600;
      inst_valid  = 1'b1;
      push_trap(32'h600, 32'h80, 32'h8000_0012, 32'h1000);
      #1;
      run_trap_seq(32'h8000_0012);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
